// File: rtl/fetch_unit_if.sv
// Bundle between the instruction fetch unit, its controller and instruction memory.
// Signal prefixes are seen from the fetch unit: i_ is driven into it, o_ is driven by it.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH   = 8,
    parameter int INST_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 3
);

    logic                    i_pcClr;
    logic                    i_pcLoad;
    logic                    i_pcInc;
    logic                    i_irLoad;
    logic                    o_instReq;
    logic [ADDR_WIDTH-1:0]   o_instAddr;
    logic                    i_instValid;
    logic [INST_WIDTH-1:0]   i_instData;
    logic [OPCODE_WIDTH-1:0] o_opcode;
    logic [ADDR_WIDTH-1:0]   o_operand;
    logic [ADDR_WIDTH-1:0]   o_pc;
    logic                    o_fetchBusy;
    logic                    o_instReady;
    logic                    o_fetchErr;
    logic                    o_overrun;
    logic                    o_pcWrap;

    modport slave (
        input  i_pcClr, i_pcLoad, i_pcInc, i_irLoad, i_instValid, i_instData,
        output o_instReq, o_instAddr, o_opcode, o_operand, o_pc,
               o_fetchBusy, o_instReady, o_fetchErr, o_overrun, o_pcWrap
    );

    modport master (
        output i_pcClr, i_pcLoad, i_pcInc, i_irLoad, i_instValid, i_instData,
        input  o_instReq, o_instAddr, o_opcode, o_operand, o_pc,
               o_fetchBusy, o_instReady, o_fetchErr, o_overrun, o_pcWrap
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, one outstanding memory fetch with timeout,
// and the instruction register whose opcode/operand fields feed the controller.
module fetch_unit #(
    parameter int ADDR_WIDTH   = 8,
    parameter int INST_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.slave   bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_pcWrap;
    logic [INST_WIDTH-1:0] r_ir;
    logic [ADDR_WIDTH-1:0] r_instAddr;
    logic                  r_instReq;
    logic                  r_instReady;
    logic                  r_fetchErr;
    logic                  r_overrun;
    logic [7:0]            r_waitCnt;

    logic [ADDR_WIDTH-1:0] w_operand;
    logic [7:0]            w_cntNext;
    logic                  w_timeout;
    logic                  w_unusedIrBits;

    assign w_operand = r_ir[ADDR_WIDTH-1:0];
    assign w_cntNext = r_waitCnt + 8'd1;
    // The fetch is abandoned on the TIMEOUT-th WAIT edge, so the request is held TIMEOUT cycles.
    assign w_timeout = (w_cntNext == TIMEOUT_CNT);

    // IR bits between the opcode and operand fields are decoded by nothing.
    assign w_unusedIrBits = ^r_ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_pcWrap <= 1'b0;
        end else if (bus.i_pcClr) begin
            r_pc     <= '0;
            r_pcWrap <= 1'b0;
        end else if (bus.i_pcLoad) begin
            r_pc <= w_operand;
        end else if (bus.i_pcInc) begin
            r_pc <= r_pc + 1'b1;
            if (r_pc == '1) begin
                r_pcWrap <= 1'b1;
            end
        end
    end

    // Fetch FSM; the PC path above runs independently so it never aborts a fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ir        <= '0;
            r_instAddr  <= '0;
            r_instReq   <= 1'b0;
            r_instReady <= 1'b0;
            r_fetchErr  <= 1'b0;
            r_overrun   <= 1'b0;
            r_waitCnt   <= '0;
        end else begin
            r_instReady <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_irLoad) begin
                        r_instAddr <= r_pc;
                        r_instReq  <= 1'b1;
                        r_waitCnt  <= '0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_irLoad) begin
                        r_overrun <= 1'b1;
                    end
                    // A response on the timeout edge still counts as a good fetch.
                    if (bus.i_instValid) begin
                        r_ir        <= bus.i_instData;
                        r_instReq   <= 1'b0;
                        r_instReady <= 1'b1;
                        r_waitCnt   <= '0;
                        r_state     <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_ir        <= '0;
                        r_fetchErr  <= 1'b1;
                        r_instReq   <= 1'b0;
                        r_instReady <= 1'b1;
                        r_waitCnt   <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_waitCnt <= w_cntNext;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_pc        = r_pc;
    assign bus.o_pcWrap    = r_pcWrap;
    assign bus.o_instReq   = r_instReq;
    assign bus.o_instAddr  = r_instAddr;
    assign bus.o_instReady = r_instReady;
    assign bus.o_fetchErr  = r_fetchErr;
    assign bus.o_overrun   = r_overrun;
    assign bus.o_fetchBusy = (r_state != ST_IDLE);
    assign bus.o_opcode    = r_ir[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign bus.o_operand   = w_operand;

endmodule
